// File: rtl/i2c_pkg.sv
// Shared state type and quarter-period constants for the I2C write master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } i2c_state_e;

  localparam int Q_START = 2;
  localparam int Q_BIT   = 4;
  localparam int Q_STOP  = 3;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;

  // Index of the final quarter of each bus phase; ACK shares the BIT shape.
  function automatic logic [1:0] last_quarter(input i2c_state_e s);
    case (s)
      ST_START: last_quarter = 2'(Q_START - 1);
      ST_STOP:  last_quarter = 2'(Q_STOP - 1);
      default:  last_quarter = 2'(Q_BIT - 1);
    endcase
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Divides the system clock into SCL quarter periods: a one-cycle tick on the
// last clock of each quarter plus a 2-bit index of the current quarter.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       wrap,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // wrap restarts the quarter index at the end of a phase shorter than four quarters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      quarter <= '0;
    end else if (clear) begin
      count   <= '0;
      quarter <= '0;
    end else if (tick) begin
      count   <= '0;
      quarter <= wrap ? 2'd0 : quarter + 2'd1;
    end else begin
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_write_master.sv
// I2C write-only master: START, address+W, NUM_BYTES data bytes with ACK checks, STOP.
// SCL and SDA come straight from flops so the pins never glitch on FSM decode.
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV   = 125,
  parameter logic [6:0] DEV_ADDR  = WM8731_ADDR,
  parameter int         NUM_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic                   i2c_scl,
  inout  wire                    i2c_sda
);

  localparam int SW  = 8 * (NUM_BYTES + 1);
  localparam int BCW = $clog2(NUM_BYTES + 1);

  i2c_state_e     state;
  i2c_state_e     state_d;
  logic [SW-1:0]  shreg;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic           err_flag;
  logic           sda_meta;
  logic           sda_sync;
  logic           sda_low;

  logic           tick;
  logic           wrap;
  logic           quarter_end;
  logic [1:0]     quarter;

  logic           accept;
  logic           shift;
  logic           ack_sample;
  logic           next_byte;
  logic           scl_d;
  logic           sda_low_d;

  assign wrap        = (quarter == last_quarter(state));
  assign quarter_end = tick && wrap;
  assign i2c_sda     = sda_low ? 1'b0 : 1'bz;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .wrap    (wrap),
    .tick    (tick),
    .quarter (quarter)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    shift      = 1'b0;
    ack_sample = 1'b0;
    next_byte  = 1'b0;
    scl_d      = 1'b1;
    sda_low_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        sda_low_d = (quarter == 2'd1);
        if (quarter_end) state_d = ST_BIT;
      end
      ST_BIT: begin
        scl_d     = quarter[1];
        sda_low_d = ~shreg[SW-1];
        if (quarter_end) begin
          shift = 1'b1;
          if (bit_cnt == 3'd7) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // A NACK still completes the ACK clock before the STOP begins
        scl_d      = quarter[1];
        ack_sample = tick && (quarter == 2'd2);
        if (quarter_end) begin
          if (err_flag || (byte_cnt == '0)) begin
            state_d = ST_STOP;
          end else begin
            state_d   = ST_BIT;
            next_byte = 1'b1;
          end
        end
      end
      ST_STOP: begin
        scl_d     = (quarter != 2'd0);
        sda_low_d = (quarter != 2'd2);
        if (quarter_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i2c_scl  <= 1'b1;
      sda_low  <= 1'b0;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      i2c_scl  <= scl_d;
      sda_low  <= sda_low_d;
      sda_meta <= i2c_sda;
      sda_sync <= sda_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      err_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shreg    <= {DEV_ADDR, 1'b0, wdata};
        bit_cnt  <= '0;
        byte_cnt <= BCW'(NUM_BYTES);
        err_flag <= 1'b0;
        ack_err  <= 1'b0;
        busy     <= 1'b1;
      end
      if (shift) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (next_byte) byte_cnt <= byte_cnt - 1'b1;
      if (ack_sample && sda_sync) err_flag <= 1'b1;
      if ((state == ST_STOP) && quarter_end) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        ack_err <= err_flag;
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: directed transactions, a bus-decoding slave model
// that ACKs or NACKs on demand, and a scoreboard checked on every done pulse.
module tb_i2c_write_master;
  import i2c_pkg::*;

  localparam int CD       = 4;
  localparam int NB       = 2;
  localparam int LAT_FULL = (36 * (NB + 1) + 5) * CD;

  typedef struct {
    int          t0;
    int          latency;
    logic        err;
    int          nbytes;
    logic [23:0] bytes;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [8*NB-1:0] wdata;
  logic          busy;
  logic          done;
  logic          ack_err;
  logic          i2c_scl;
  wire           sda_bus;
  logic          slave_drive = 1'b0;

  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            nack_slot = -1;
  int            last_t0 = 0;
  exp_t          sb[$];

  pullup (sda_bus);
  assign sda_bus = slave_drive ? 1'b0 : 1'bz;

  i2c_write_master #(
    .CLK_DIV   (CD),
    .DEV_ADDR  (7'h1A),
    .NUM_BYTES (NB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .i2c_scl (i2c_scl),
    .i2c_sda (sda_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives a start request; caller is positioned before the accepting edge.
  task automatic applyStimulus(input logic [15:0] data, input int nack, input logic [23:0] exp_bytes,
                               input int nbytes, input int lat, input logic err, input bit push);
    exp_t e;
    start     = 1'b1;
    wdata     = data;
    nack_slot = nack;
    @(posedge clk);
    #1;
    start   = 1'b0;
    last_t0 = cyc;
    if (push) begin
      e.t0      = cyc;
      e.latency = lat;
      e.err     = err;
      e.nbytes  = nbytes;
      e.bytes   = exp_bytes;
      sb.push_back(e);
    end
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles, required a done pulse", budget);
    end
  endtask

  // Slave model and scoreboard monitor, sampled on the falling clock edge.
  initial begin : monitor
    logic        prev_scl, prev_sda, cur_scl, cur_sda, rise_seen;
    int          bitcnt, slot, hi_len, lo_len, low_before, starts, stops;
    logic [7:0]  shbyte;
    logic [7:0]  decoded[$];
    logic [23:0] got;
    exp_t        e;
    prev_scl = 1'b1; prev_sda = 1'b1; rise_seen = 1'b0;
    bitcnt = 0; slot = 0; hi_len = 0; lo_len = 0; low_before = 0; starts = 0; stops = 0;
    shbyte = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_scl = 1'b1; prev_sda = 1'b1; rise_seen = 1'b0;
        bitcnt = 0; slot = 0; hi_len = 0; lo_len = 0; starts = 0; stops = 0;
        decoded.delete();
        slave_drive = 1'b0;
      end else begin
        cur_scl = i2c_scl;
        cur_sda = sda_bus;
        if (prev_scl && cur_scl && (cur_sda !== prev_sda)) begin
          if (!cur_sda) begin
            starts++;
            bitcnt = 0; slot = 0; rise_seen = 1'b0;
            decoded.delete();
          end else begin
            stops++;
          end
        end
        if (!prev_scl && cur_scl) begin
          low_before = lo_len;
          hi_len     = 1;
          rise_seen  = 1'b1;
          if (bitcnt < 8) shbyte = {shbyte[6:0], cur_sda};
          bitcnt++;
          if (bitcnt == 8) decoded.push_back(shbyte);
        end else if (prev_scl && !cur_scl) begin
          if (rise_seen) begin
            checkOutput("scl_high_len", hi_len, 2 * CD);
            checkOutput("scl_low_len", low_before, 2 * CD);
          end
          lo_len = 1;
          if (bitcnt == 8) begin
            slave_drive = (slot != nack_slot);
          end else if (bitcnt == 9) begin
            slave_drive = 1'b0;
            bitcnt      = 0;
            slot++;
          end
        end else if (cur_scl) begin
          hi_len++;
        end else begin
          lo_len++;
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;

        if (done) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_done: got done=1, required no pending transaction (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            checkOutput("done_latency", cyc - e.t0, e.latency);
            checkOutput("ack_err", {31'd0, ack_err}, {31'd0, e.err});
            checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
            checkOutput("byte_count", decoded.size(), e.nbytes);
            got = '0;
            foreach (decoded[i]) if (i < 3) got[23-8*i -: 8] = decoded[i];
            checkOutput("bus_bytes", {8'd0, got}, {8'd0, e.bytes});
            checkOutput("start_conditions", starts, 1);
            checkOutput("stop_conditions", stops, 1);
          end
          starts = 0;
          stops  = 0;
        end
      end
    end
  end

  initial begin : driver
    int done_cyc;
    int n;
    reset = 1'b1;
    start = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_scl", {31'd0, i2c_scl}, 32'd1);
    checkOutput("reset_sda", {31'd0, sda_bus}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_ack_err", {31'd0, ack_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] all bytes acknowledged, plus an ignored mid-transaction start");
    applyStimulus(16'h1E00, -1, 24'h341E00, 3, LAT_FULL, 1'b0, 1'b1);
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    checkOutput("sda_released_after_accept", {31'd0, sda_bus}, 32'd1);
    waitCycle(last_t0 + CD);
    checkOutput("sda_before_start_edge", {31'd0, sda_bus}, 32'd1);
    waitCycle(last_t0 + CD + 1);
    checkOutput("sda_start_edge", {31'd0, sda_bus}, 32'd0);
    checkOutput("scl_during_start", {31'd0, i2c_scl}, 32'd1);
    waitCycle(last_t0 + 2 * CD);
    checkOutput("scl_before_first_fall", {31'd0, i2c_scl}, 32'd1);
    waitCycle(last_t0 + 2 * CD + 1);
    checkOutput("scl_first_fall", {31'd0, i2c_scl}, 32'd0);
    waitCycle(last_t0 + 100);
    start = 1'b1;
    wdata = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    waitDone(600);

    $display("[TB] NACK on address byte");
    @(negedge clk);
    applyStimulus(16'hA55A, 0, 24'h340000, 1, (2 + 36 + 3) * CD, 1'b1, 1'b1);
    waitDone(300);

    $display("[TB] NACK on second data byte");
    @(negedge clk);
    applyStimulus(16'h8001, 2, 24'h348001, 3, LAT_FULL, 1'b1, 1'b1);
    waitDone(600);

    $display("[TB] NACK on first data byte");
    @(negedge clk);
    applyStimulus(16'h7F3C, 1, 24'h347F00, 2, (2 + 72 + 3) * CD, 1'b1, 1'b1);
    waitDone(400);
    @(negedge clk);
    checkOutput("done_pulse_width", {31'd0, done}, 32'd0);
    checkOutput("ack_err_hold", {31'd0, ack_err}, 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("ack_err_hold_later", {31'd0, ack_err}, 32'd1);

    $display("[TB] back-to-back transactions");
    applyStimulus(16'hC3A5, -1, 24'h34C3A5, 3, LAT_FULL, 1'b0, 1'b1);
    checkOutput("ack_err_clear_on_accept", {31'd0, ack_err}, 32'd0);
    waitDone(600);
    done_cyc = cyc;
    applyStimulus(16'h0102, -1, 24'h340102, 3, LAT_FULL, 1'b0, 1'b1);
    checkOutput("b2b_accept_cycle", last_t0, done_cyc + 1);
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    waitDone(600);

    $display("[TB] reset in the middle of the address byte");
    @(negedge clk);
    applyStimulus(16'h5555, -1, 24'h0, 0, 0, 1'b0, 1'b0);
    waitCycle(last_t0 + 11);
    checkOutput("pre_reset_scl_low", {31'd0, i2c_scl}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_scl", {31'd0, i2c_scl}, 32'd1);
    checkOutput("abort_sda", {31'd0, sda_bus}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(16'h1234, -1, 24'h341234, 3, LAT_FULL, 1'b0, 1'b1);
    waitDone(600);

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    repeat (40) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
